// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory stage: execute bundle, memory op kinds, stage states.
package mem_stage_pkg;

    localparam logic [31:0] FRAMEBUFFER = 32'h0100_0000;
    localparam logic [31:0] FB_SIZE     = 32'h0004_0000;

    typedef enum logic [3:0] {
        MemNone, LoadByte, LoadHalf, LoadWord, ULoadByte, ULoadHalf,
        StoreByte, StoreHalf, StoreWord
    } MemType;

    typedef enum logic [1:0] {Idle, Req, Resp} MemState;

    // wdata is 33 bits: bit 32 marks results that did not come from a load
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] reg2;
        logic [32:0] wdata;
        MemType      memtype;
        logic        memr;
        logic        memw;
        logic        wback;
        logic [3:0]  aluop;
    } Signals;

    function automatic logic [2:0] sizeof_memtype(MemType mt);
        return (mt == LoadWord || mt == StoreWord) ? 3'd4 :
               (mt == LoadHalf || mt == ULoadHalf || mt == StoreHalf) ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane steering for stores and extraction/extension for loads.
module mem_align
    import mem_stage_pkg::*;
(
    input  MemType      i_mt,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_misalign
);
    logic [2:0]  w_size;
    logic [31:0] w_sh;

    assign w_size     = sizeof_memtype(i_mt);
    assign w_sh       = i_rdata >> {i_off, 3'b000};
    assign o_misalign = (w_size == 3'd2 && i_off[0]) || (w_size == 3'd4 && i_off != 2'd0);
    assign o_load     = i_mt == LoadByte  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                        i_mt == LoadHalf  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                        i_mt == ULoadByte ? {24'b0, w_sh[7:0]} :
                        i_mt == ULoadHalf ? {16'b0, w_sh[15:0]} : i_rdata;
    assign o_wstrb    = i_mt == StoreByte ? 4'b0001 << i_off :
                        i_mt == StoreHalf ? 4'b0011 << i_off :
                        i_mt == StoreWord ? 4'hF : 4'h0;
    assign o_wdata    = i_mt == StoreByte ? {4{i_reg2[7:0]}} :
                        i_mt == StoreHalf ? {2{i_reg2[15:0]}} : i_reg2;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: runs one bus transaction per load/store and passes other ops through to writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] FB_BASE = FRAMEBUFFER,
    parameter logic [31:0] FB_SZ   = FB_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  Signals      sig_in,
    output logic        out_valid,
    input  logic        out_ready,
    output Signals      sig_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    output logic        mem_fb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        misalign
);
    MemState     r_state;
    Signals      r_sig;
    MemType      w_mt;
    logic [1:0]  w_off;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_load;
    logic        w_acc, w_memop, w_mis_raw, w_mis, w_fb;

    assign in_ready = r_state == Idle && (!out_valid || out_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_memop  = sig_in.memr || sig_in.memw;
    assign w_mis    = w_memop && w_mis_raw;
    assign w_fb     = (sig_in.wdata[31:0] & ~(FB_SZ - 32'd1)) == FB_BASE;
    // lanes come from the incoming bundle when idle, from the latched one while waiting on the bus
    assign w_mt     = r_state == Idle ? sig_in.memtype : r_sig.memtype;
    assign w_off    = r_state == Idle ? sig_in.wdata[1:0] : r_sig.wdata[1:0];
    assign sig_out  = r_sig;

    mem_align u_align (
        .i_mt      (w_mt),
        .i_off     (w_off),
        .i_reg2    (sig_in.reg2),
        .i_rdata   (mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_load    (w_load),
        .o_misalign(w_mis_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= Idle;
            r_sig     <= '0;
            out_valid <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            mem_fb    <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (r_state == Idle) begin
                if (w_acc && w_memop && !w_mis) begin
                    r_sig     <= sig_in;
                    out_valid <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_we    <= sig_in.memw;
                    mem_addr  <= {sig_in.wdata[31:2], 2'b00};
                    mem_wstrb <= sig_in.memw ? w_wstrb : 4'h0;
                    mem_wdata <= w_wdata;
                    mem_fb    <= w_fb;
                    r_state   <= Req;
                end else if (w_acc) begin
                    r_sig       <= sig_in;
                    r_sig.wback <= sig_in.wback && !w_mis;
                    out_valid   <= 1'b1;
                    misalign    <= w_mis;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end else if (r_state == Req) begin
                if (mem_ack) begin
                    mem_req   <= 1'b0;
                    out_valid <= 1'b1;
                    r_state   <= Resp;
                    if (!r_sig.memw)
                        r_sig.wdata <= {1'b0, w_load};
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                r_state   <= Idle;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (!rst && w_acc) assert (!(sig_in.memr && sig_in.memw));
`endif
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute; consumes the Common::Signals bundle that execute produces.
- For loads and stores, runs a single-outstanding request/acknowledge transaction on the data bus, aligns byte lanes, and sign- or zero-extends load data into wdata.
- Non-memory instructions pass through with one register stage.
- Feeds writeback with a valid/ready handshake and stalls execute while a bus access is pending.

Parameters:
- FB_BASE, 32'h0100_0000, framebuffer base; power of two; equals Mem::framebuffer.
- FB_SIZE, 32'h0004_0000, framebuffer window size in bytes; power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute presents a valid bundle.
- in_ready  out  1  stage accepts the bundle this cycle.
- sig_in  in  Common::Signals  execute bundle; address = wdata[31:0]; store data = reg2.
- out_valid  out  1  sig_out valid to writeback.
- out_ready  in  1  writeback accepts.
- sig_out  out  Common::Signals  bundle with wdata replaced by load data for loads.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address (addr & ~3).
- mem_wstrb  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_fb  out  1  address falls in [FB_BASE, FB_BASE+FB_SIZE).
- mem_ack  in  1  bus completes; mem_rdata valid the same cycle.
- mem_rdata  in  32  read data.
- misalign  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (asynchronous, active-high): state IDLE.
  - out_valid=0, mem_req=0, mem_we=0, mem_wstrb=0, misalign=0.
  - mem_addr=0, mem_wdata=0, mem_fb=0.
  - sig_out register cleared to zero.
- in_ready is asserted only when state is IDLE and (out_valid=0 or out_ready=1). A bundle is accepted when in_valid and in_ready are both 1.
- IDLE, accepting a bundle with memr=0 and memw=0: register it into sig_out; out_valid=1 next cycle (latency 1); state stays IDLE.
- IDLE, accepting a bundle with memr or memw set, aligned address:
  - Latch the bundle; go to REQ.
  - mem_req=1 from the next cycle; bus outputs are registered and held stable until ack.
- REQ: hold mem_req until mem_ack=1.
  - On ack, capture mem_rdata and drop mem_req.
  - Loads: wdata = {1'b0, extended}. Stores: wdata is unchanged.
  - Go to RESP with out_valid=1.
- RESP: hold sig_out until out_ready=1, then return to IDLE with out_valid=0. The next accept happens in a later IDLE cycle, so a memory op costs at least 3 cycles.
- mem_ack while not in REQ: ignored.
- Alignment:
  - Half-word accesses need addr[0]=0; word accesses need addr[1:0]=0.
  - A misaligned access pulses misalign for 1 cycle, issues no bus request, and is passed through like a non-memory op with wback forced to 0.
- Store lanes, with o = addr[1:0]:
  - StoreByte: wstrb = 1<<o; wdata = reg2[7:0] replicated 4×.
  - StoreHalf: wstrb = 4'b0011<<o; wdata = reg2[15:0] replicated 2×.
  - StoreWord: wstrb = 4'hF; wdata = reg2.
- Load extraction: select the byte or half at o from mem_rdata.
  - LoadByte and LoadHalf sign-extend.
  - ULoadByte and ULoadHalf zero-extend.
  - LoadWord passes mem_rdata through.
  - mem_wstrb = 0 for loads.
- memr and memw both set: illegal. Treat as a store and `err in simulation.
- Reset mid-transaction: state returns to IDLE immediately and mem_req drops asynchronously. The bus must tolerate an abandoned request.
- Fields of sig_out other than wdata and wback equal the accepted sig_in.

Decomposition:
- Add to package Common:
  - typedef enum MemState {Idle, Req, Resp}.
  - Function sizeof_memtype(MemType) returning a byte count 1, 2 or 4.
- Add FB_SIZE to package Mem beside framebuffer.
- One combinational sub-module, mem_align: MemType, offset, reg2 and rdata in; wstrb, wdata, load value and misalign out. It is shared with a future I-cache refill path.

Test Plan:
- Non-memory op: Add bundle, out_ready=1 -> out_valid next cycle; sig_out equals sig_in; no mem_req.
- StoreByte at 0x1000_0003 with reg2=0x1234_56AB -> mem_addr=0x1000_0000, wstrb=4'b1000, wdata=0xABAB_ABAB; ack after 2 wait cycles -> out_valid the cycle after ack.
- LoadHalf at 0x0100_0002 with rdata=0x8001_0000 -> mem_fb=1; wdata=0x0_FFFF_8001. Same access as ULoadHalf -> wdata=0x0_0000_8001.
- LoadWord at 0x0000_0006 -> misalign pulse, no mem_req, out wback=0.
- Backpressure: out_ready=0 for 3 cycles in RESP -> sig_out stable and in_ready=0 throughout; accept resumes after out_ready=1.
- Assert rst while in REQ -> mem_req, out_valid and misalign are 0 within the same cycle; next bundle after deassert completes normally.
